// File: rtl/sin_tone_player.sv
`default_nettype none
// ============================================================================
// Module   : sin_tone_player
// Purpose  : Tone sequencer. It steps a phase accumulator, issues sine-table
//            addresses on sample ticks, and returns the table samples with a
//            valid strobe. Optional macro TONE_VOLUME_EN adds vol_shift
//            attenuation.
// Revision : 1.0 - initial release
// ============================================================================
module sin_tone_player #(
    parameter int COUNT_SIZE = 8,
    parameter int PHASE_W    = 16,
    parameter int DUR_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  start,
    input  logic [PHASE_W-1:0]    freq_inc,
    input  logic [DUR_W-1:0]      duration,
`ifdef TONE_VOLUME_EN
    input  logic [2:0]            vol_shift,
`endif
    input  logic                  sample_tick,
    output logic [COUNT_SIZE-1:0] ADDR,
    input  logic [15:0]           Q,
    output logic [15:0]           sample_out,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // The top-bits value with no table entry is redirected to address 0.
    localparam logic [COUNT_SIZE-1:0] NO_ENTRY_ADDR = '1;

    state_t                  state_q, state_d;
    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [PHASE_W-1:0]      inc_q, inc_d;
    logic [DUR_W-1:0]        rem_q, rem_d;
    logic [COUNT_SIZE-1:0]   addr_q, addr_d;
    logic [1:0]              pipe_q, pipe_d;
    logic [15:0]             sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic [COUNT_SIZE-1:0]   w_top_bits;
    logic [15:0]             w_q_scaled;

    assign w_top_bits = phase_q[PHASE_W-1 -: COUNT_SIZE];

`ifdef TONE_VOLUME_EN
    logic [2:0] vol_q, vol_d;

    assign w_q_scaled = 16'($signed(Q) >>> vol_q);
`else
    assign w_q_scaled = Q;
`endif

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        inc_d    = inc_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        pipe_d   = {pipe_q[0], 1'b0};
`ifdef TONE_VOLUME_EN
        vol_d    = vol_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (duration != '0) begin
                        state_d = ST_PLAY;
                        inc_d   = freq_inc;
                        rem_d   = duration;
                        phase_d = '0;
`ifdef TONE_VOLUME_EN
                        vol_d   = vol_shift;
`endif
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (sample_tick) begin
                    addr_d    = (w_top_bits == NO_ENTRY_ADDR) ? '0 : w_top_bits;
                    phase_d   = phase_q + inc_q;
                    rem_d     = rem_q - DUR_W'(1);
                    pipe_d[0] = 1'b1;
                    if (rem_q == DUR_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Stage 1 empty means this edge delivers the last sample.
                if (!pipe_q[0]) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d  = pipe_q[1];
        sample_d = pipe_q[1] ? w_q_scaled : sample_q;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            inc_q    <= '0;
            rem_q    <= '0;
            addr_q   <= '0;
            pipe_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef TONE_VOLUME_EN
            vol_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            inc_q    <= inc_d;
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            pipe_q   <= pipe_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
`ifdef TONE_VOLUME_EN
            vol_q    <= vol_d;
`endif
        end
    end

    assign ADDR         = addr_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sin_tone_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_sin_tone_player
// Purpose  : Randomized self-checking bench for sin_tone_player with a sine
//            table model and a cycle-level expected-sample scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sin_tone_player;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        start = 1'b0;
    logic        sample_tick = 1'b0;
    logic [15:0] freq_inc = '0;
    logic [15:0] duration = '0;
    logic [7:0]  ADDR;
    logic [15:0] Q = '0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic        done;
`ifdef TONE_VOLUME_EN
    logic [2:0]  vol_shift = '0;
`endif

    sin_tone_player #(
        .COUNT_SIZE (8),
        .PHASE_W    (16),
        .DUR_W      (16)
    ) dut (
        .CLK          (CLK),
        .RESETn       (RESETn),
        .start        (start),
        .freq_inc     (freq_inc),
        .duration     (duration),
`ifdef TONE_VOLUME_EN
        .vol_shift    (vol_shift),
`endif
        .sample_tick  (sample_tick),
        .ADDR         (ADDR),
        .Q            (Q),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Sine table: 255 entries, amplitude 16000; slot 255 is a poison value.
    logic [15:0] rom [0:255];
    always @(posedge CLK) Q <= rom[ADDR];

    int errors = 0;
    int checks = 0;
    logic [7:0]  exp_addr = '0;
    logic [15:0] exp_out  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_addr(input int n, input logic [15:0] f);
        longint ph;
        longint top;
        ph  = (longint'(n) * longint'(f)) % 65536;
        top = ph / 256;
        return (top == 255) ? 8'd0 : 8'(top);
    endfunction

    function automatic logic [15:0] ref_sample(input logic [7:0] a, input logic [2:0] vs);
        int v;
        v = int'($signed(rom[a]));
`ifdef TONE_VOLUME_EN
        v = $rtoi($floor(real'(v) / real'(1 << vs)));
`else
        if (vs == 3'd7) v = v + 0;
`endif
        return 16'(v);
    endfunction

    function automatic logic pick_tick(input int mode, input int k);
        case (mode)
            0:       return (k % 4) == 2;
            1:       return 1'b1;
            default: return ($urandom % 3) == 0;
        endcase
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_addr"},  32'(ADDR), 32'(exp_addr));
        chk({tag, "_out"},   32'(sample_out), 32'(exp_out));
        chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
    endtask

    task automatic reset_mid();
        #2 RESETn = 1'b0;
        #1;
        exp_addr = '0;
        exp_out  = '0;
        check_quiet("rst_async");
        start = 1'b0;
        sample_tick = 1'b1;
        @(posedge CLK); #1;
        check_quiet("rst_hold");
        #1 RESETn = 1'b1;
        repeat (4) begin
            @(posedge CLK); #1;
            check_quiet("rst_after");
        end
        sample_tick = 1'b0;
    endtask

    task automatic play_note(input logic [15:0] f, input logic [15:0] d, input int mode,
                             input logic [2:0] vs, input bit mid_start, input int abort_at);
        int          ticks;
        int          seen;
        bit          ended;
        bit          exp_valid;
        bit          exp_done;
        logic        tick_drv;
        logic [7:0]  a;
        int          due[$];
        logic [15:0] vals[$];
        ticks = 0;
        seen  = 0;
        ended = 1'b0;
        start = 1'b1;
        freq_inc = f;
        duration = d;
`ifdef TONE_VOLUME_EN
        vol_shift = vs;
`endif
        sample_tick = (mode == 1) ? 1'b1 : 1'($urandom % 2);
        for (int k = 0; k < 3000 && !ended; k++) begin
            tick_drv = sample_tick;
            @(posedge CLK); #1;
            if (k > 0 && d != 0 && tick_drv && ticks < int'(d)) begin
                a = ref_addr(ticks, f);
                exp_addr = a;
                due.push_back(cyc + 2);
                vals.push_back(ref_sample(a, vs));
                ticks++;
            end
            exp_valid = (due.size() > 0) && (due[0] == cyc);
            if (exp_valid) begin
                exp_out = vals.pop_front();
                void'(due.pop_front());
                seen++;
            end
            exp_done = (d == 0) ? (k == 0) : (exp_valid && ticks == int'(d) && due.size() == 0);
            if (exp_done) ended = 1'b1;
            chk("addr",   32'(ADDR), 32'(exp_addr));
            chk("valid",  32'(sample_valid), 32'(exp_valid));
            chk("sample", 32'(sample_out), 32'(exp_out));
            chk("done",   32'(done), 32'(exp_done));
            chk("busy",   32'(busy), 32'(d != 0 && !ended));
            if (!ended && abort_at >= 0 && seen == abort_at) begin
                reset_mid();
                return;
            end
            // Inputs change after acceptance; latched values must be used.
            start    = mid_start && (k == 0);
            freq_inc = 16'($urandom);
            duration = 16'($urandom);
`ifdef TONE_VOLUME_EN
            vol_shift = 3'($urandom);
`endif
            sample_tick = pick_tick(mode, k);
        end
        if (!ended) chk("timeout", 32'd1, 32'd0);
        start = 1'b0;
        repeat (3) begin
            sample_tick = 1'($urandom % 2);
            @(posedge CLK); #1;
            check_quiet("idle_tail");
        end
        sample_tick = 1'b0;
    endtask

    initial begin
        real v;
        for (int i = 0; i < 255; i++) begin
            v = 16000.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 256.0);
            v = v + ((v >= 0.0) ? 1.0e-6 : -1.0e-6);
            rom[i] = 16'($rtoi(v));
        end
        rom[255] = 16'hDEAD;

        RESETn = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_quiet("reset");
        RESETn = 1'b1;
        @(posedge CLK); #1;

        play_note(16'h0100, 16'd3, 0, 3'd0, 1'b0, -1);
        play_note(16'h4000, 16'd5, 1, 3'd0, 1'b0, -1);
        play_note(16'hFF00, 16'd3, 1, 3'd0, 1'b0, -1);
        play_note(16'h0777, 16'd0, 2, 3'd0, 1'b0, -1);
        play_note(16'h1234, 16'd2, 2, 3'd0, 1'b1, -1);
        play_note(16'h0321, 16'd10, 1, 3'd0, 1'b0, 2);
        play_note(16'h0800, 16'd4, 2, 3'd0, 1'b0, -1);
        play_note(16'h4000, 16'd5, 1, 3'd2, 1'b0, -1);
        for (int n = 0; n < 8; n++) begin
            play_note(16'($urandom), 16'($urandom_range(1, 12)), int'($urandom_range(0, 2)),
                      3'($urandom), 1'($urandom % 2), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sin_tone_player.md
# sin_tone_player

Tone sequencer that drives the address side of the synchronous sine lookup table and collects its samples. On a start request it latches a phase step and a sample count, runs a phase accumulator, and issues one table address per sample-rate tick. It absorbs the table's one-cycle registered read latency and emits each returned sample with a one-cycle valid strobe toward the audio output path. It pulses `done` when the note ends.

## Interface
- COUNT_SIZE, 8: table address width; the table holds 2**COUNT_SIZE-1 entries.
- PHASE_W, 16: phase accumulator width; must be ≥ COUNT_SIZE.
- DUR_W, 16: sample-count width.
- CLK  in  1  system clock; all logic is on the rising edge.
- RESETn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle note request; honoured only in IDLE.
- freq_inc  in  PHASE_W  phase step per sample; latched on an accepted start.
- duration  in  DUR_W  number of samples to play; latched on an accepted start.
- sample_tick  in  1  sample-rate strobe; may be high on any number of consecutive cycles.
- ADDR  out  COUNT_SIZE  address to the sine table.
- Q  in  16  table data; valid on the cycle after ADDR changes (registered read).
- sample_out  out  16  signed sample returned by the table.
- sample_valid  out  1  one-cycle strobe qualifying sample_out.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse at note end.

## Operation
- States:
  - IDLE: waiting for a note request.
  - PLAY: issuing addresses.
  - DRAIN: waiting for in-flight samples to return.
- IDLE → PLAY on start when duration≠0.
  - Latch freq_inc and duration.
  - Clear the phase accumulator to 0.
- IDLE with start and duration=0: latch nothing, issue no address; pulse done on the next cycle; busy stays low.
- PLAY, on each sample_tick:
  - ADDR <= phase[PHASE_W-1 -: COUNT_SIZE].
  - phase <= phase + freq_inc, modulo 2**PHASE_W (wraps silently).
  - Decrement the remaining count.
  - Push a valid bit into a 2-stage pipeline.
- Address mapping: the top-bits value 2**COUNT_SIZE-1 has no table entry and is driven as 0.
- PLAY → DRAIN on the tick that issues the last address (remaining count = 1).
- DRAIN → IDLE when the pipeline is empty; done pulses on the same edge as the final sample_valid.
- sample_tick is ignored in IDLE and DRAIN. start is ignored whenever busy=1.
- sample_out <= Q when the pipeline stage-2 bit is set; otherwise it holds its last value.
- Reset (asserted in any state, including mid-note) forces:
  - state IDLE, phase 0, pipeline cleared.
  - ADDR 0, sample_out 0x0000.
  - sample_valid, busy and done all 0.

## Timing
- Tick sampled at edge k: ADDR is updated at edge k, Q at edge k+1, sample_out/sample_valid at edge k+2.
- Tick-to-sample latency is 2 cycles.
- Back-to-back ticks give back-to-back sample_valid cycles with no bubbles.
- busy rises on the edge that accepts start and falls on the edge that pulses done.
- The first address (0) is issued on the first tick after start, not on the start cycle itself.
- A start and a tick in the same IDLE cycle: the start is accepted and the tick is ignored.

## Configuration
- TONE_VOLUME_EN defined:
  - Adds input port vol_shift [2:0], latched on an accepted start.
  - sample_out = Q >>> vol_shift (arithmetic, sign-preserving).
- TONE_VOLUME_EN undefined: vol_shift is absent and sample_out = Q unchanged.

## Test plan
- freq_inc=0x0100, duration=3, ticks every 4 cycles:
  - ADDR 0, 1, 2.
  - sample_out 0x0000, 0x0188, 0x0311, each valid exactly 2 cycles after its tick.
  - One done pulse, coincident with the third sample_valid.
- freq_inc=0x4000, duration=5, sample_tick held high:
  - ADDR 0, 64, 128, 192, 0 on consecutive cycles.
  - sample_out 0x0000, 0x3E80, 0x0000, 0xC180, 0x0000 on 5 consecutive valid cycles.
- freq_inc=0xFF00, duration=3:
  - ADDR 0, 0 (mapped from 255), 254.
  - The phase wraps without a stall.
- start with duration=0: no address change, no sample_valid, busy stays 0, done pulses one cycle later. Then start with duration=2 while busy; a second start mid-note is ignored, so exactly 2 samples are produced.
- RESETn pulsed low mid-note (after 2 of 10 samples): all outputs read 0 immediately; no further sample_valid; a new start then plays from ADDR 0.
- With TONE_VOLUME_EN, vol_shift=2, freq_inc=0x4000:
  - 0x3E80 → 0x0FA0.
  - 0xC180 → 0xF060.
